// File: rtl/crossbar_route_ctrl.sv
// Route controller for a 5-switch 4x4 crossbar. It searches the configurations from
// lowest to highest, one candidate per cycle, for the first one that realises the requested permutation.
module crossbar_route_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [7:0] req_dst,
    output logic       req_ready,
    output logic       resp_valid,
    output logic       resp_ok,
    output logic [4:0] resp_ctrl,
    output logic [5:0] resp_tries,
    output logic [4:0] control,
    output logic       busy
);

    typedef enum logic {IDLE, SEARCH} state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [4:0] r_cand;
    logic [7:0] r_dst;
    logic       r_dup_pend;
    logic [4:0] r_control;
    logic       r_resp_valid;
    logic       r_resp_ok;
    logic [4:0] r_resp_ctrl;
    logic [5:0] r_resp_tries;

    logic       w_accept;
    logic       w_perm;
    logic       w_match;
    logic [1:0] w_a, w_b, w_y, w_w, w_x, w_z;
    logic [1:0] w_src [4];
    logic [7:0] w_map;

    // Each wire carries the index of the input it is connected to; w_src[k] feeds output k.
    always_comb begin
        w_a = r_cand[0] ? 2'd1 : 2'd0;
        w_b = r_cand[0] ? 2'd0 : 2'd1;
        w_y = r_cand[3] ? 2'd3 : 2'd2;
        w_w = r_cand[3] ? 2'd2 : 2'd3;
        w_x = r_cand[2] ? w_y : w_b;
        w_z = r_cand[2] ? w_b : w_y;
        w_src[0] = r_cand[1] ? w_x : w_a;
        w_src[1] = r_cand[1] ? w_a : w_x;
        w_src[2] = r_cand[4] ? w_w : w_z;
        w_src[3] = r_cand[4] ? w_z : w_w;
        // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
        w_map = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (w_src[k] == 2'(i)) begin
                    w_map[2*i +: 2] = 2'(k);
                end
            end
        end
    end

    assign w_match  = (w_map == r_dst);
    assign w_accept = req_valid && (r_state == IDLE);
    assign w_perm   = (req_dst[1:0] != req_dst[3:2]) && (req_dst[1:0] != req_dst[5:4]) &&
                      (req_dst[1:0] != req_dst[7:6]) && (req_dst[3:2] != req_dst[5:4]) &&
                      (req_dst[3:2] != req_dst[7:6]) && (req_dst[5:4] != req_dst[7:6]);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_perm) w_next_state = SEARCH;
            SEARCH:  if (w_match || (r_cand == 5'd31)) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cand       <= '0;
            r_dst        <= '0;
            r_dup_pend   <= 1'b0;
            r_control    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_ok    <= 1'b0;
            r_resp_ctrl  <= '0;
            r_resp_tries <= '0;
        end else begin
            r_state      <= w_next_state;
            r_resp_valid <= 1'b0;
            r_dup_pend   <= w_accept && !w_perm;
            if (w_accept) begin
                r_dst  <= req_dst;
                r_cand <= '0;
            end
            // A rejected duplicate reports one cycle after accept, matching the fastest search.
            if (r_dup_pend) begin
                r_resp_valid <= 1'b1;
                r_resp_ok    <= 1'b0;
                r_resp_tries <= 6'd0;
            end
            if (r_state == SEARCH) begin
                if (w_match) begin
                    r_resp_valid <= 1'b1;
                    r_resp_ok    <= 1'b1;
                    r_resp_ctrl  <= r_cand;
                    r_resp_tries <= {1'b0, r_cand} + 6'd1;
                    r_control    <= r_cand;
                end else if (r_cand == 5'd31) begin
                    r_resp_valid <= 1'b1;
                    r_resp_ok    <= 1'b0;
                    r_resp_tries <= 6'd32;
                end else begin
                    r_cand <= r_cand + 5'd1;
                end
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state == SEARCH);
    assign resp_valid = r_resp_valid;
    assign resp_ok    = r_resp_ok;
    assign resp_ctrl  = r_resp_ctrl;
    assign resp_tries = r_resp_tries;
    assign control    = r_control;

endmodule

// File: tb/tb_crossbar_route_ctrl.sv
// Scoreboard bench for crossbar_route_ctrl: a path-tracing crossbar model predicts each response,
// a negedge monitor pops and compares it, including the cycle it appears in.
module tb_crossbar_route_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [7:0] req_dst;
    logic       req_ready;
    logic       resp_valid;
    logic       resp_ok;
    logic [4:0] resp_ctrl;
    logic [5:0] resp_tries;
    logic [4:0] control;
    logic       busy;

    crossbar_route_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_dst   (req_dst),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ok   (resp_ok),
        .resp_ctrl (resp_ctrl),
        .resp_tries(resp_tries),
        .control   (control),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        ok;
        logic [4:0]  ctrl;
        logic [5:0]  tries;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Trace one input through the switches: wire ids 0=a 1=b 2=y 3=w.
    function automatic int dest_of(input logic [4:0] c, input int src);
        int wid;
        case (src)
            0:       wid = c[0] ? 1 : 0;
            1:       wid = c[0] ? 0 : 1;
            2:       wid = c[3] ? 3 : 2;
            default: wid = c[3] ? 2 : 3;
        endcase
        case (wid)
            0:       return c[1] ? 1 : 0;
            1:       return c[2] ? (c[4] ? 3 : 2) : (c[1] ? 0 : 1);
            2:       return c[2] ? (c[1] ? 0 : 1) : (c[4] ? 3 : 2);
            default: return c[4] ? 2 : 3;
        endcase
    endfunction

    function automatic bit routes(input logic [4:0] c, input logic [7:0] dst);
        for (int s = 0; s < 4; s++) begin
            if (dest_of(c, s) != int'(dst[2*s +: 2])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic exp_t predict(input logic [7:0] dst, input int unsigned acc);
        exp_t e;
        logic [3:0] seen = '0;
        for (int s = 0; s < 4; s++) seen[dst[2*s +: 2]] = 1'b1;
        e.ok = 1'b0; e.ctrl = 5'd0; e.tries = 6'd32; e.at = acc + 32;
        if (seen != 4'hF) begin
            e.tries = 6'd0;
            e.at    = acc + 1;
            return e;
        end
        for (int c = 0; c < 32; c++) begin
            if (routes(5'(c), dst)) begin
                e.ok = 1'b1; e.ctrl = 5'(c); e.tries = 6'(c + 1); e.at = acc + c + 1;
                return e;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (resp_valid === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp: got ok=%b tries=%0d at cycle %0d, none expected", resp_ok, resp_tries, cyc);
            end else begin
                e = sb.pop_front();
                if (resp_ok !== e.ok || resp_tries !== e.tries || cyc !== e.at ||
                    (e.ok && (resp_ctrl !== e.ctrl || control !== e.ctrl))) begin
                    n_bad++;
                    $display("FAIL resp: got ok=%b ctrl=%0d tries=%0d control=%0d cyc=%0d, want ok=%b ctrl=%0d tries=%0d cyc=%0d",
                             resp_ok, resp_ctrl, resp_tries, control, cyc, e.ok, e.ctrl, e.tries, e.at);
                end
            end
        end
    end

    // Called at a negedge; request is accepted on the following posedge.
    task automatic send(input logic [7:0] dst);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: got %b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_dst   = dst;
        sb.push_back(predict(dst, cyc + 1));
        @(negedge clk);
        req_valid = 1'b0;
        req_dst   = 8'($urandom);
    endtask

    task automatic wait_resp();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (resp_valid !== 1'b1 && k < 40);
        n_cmp++;
        if (resp_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL resp_timeout: got no resp_valid in %0d cycles, want one", k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_dst = 8'h00;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, busy, resp_valid, resp_ok, resp_ctrl, resp_tries, control} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0}) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%b busy=%b v=%b ok=%b ctrl=%0d tries=%0d control=%0d, want 1 0 0 0 0 0 0",
                     req_ready, busy, resp_valid, resp_ok, resp_ctrl, resp_tries, control);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        send(8'hE4);
        wait_resp();
    endtask

    task automatic test_swap();
        send(8'hE1);
        wait_resp();
        @(negedge clk);
        n_cmp++;
        if (resp_valid !== 1'b0 || resp_ctrl !== 5'd1 || resp_tries !== 6'd2 || control !== 5'd1) begin
            n_bad++;
            $display("FAIL swap_hold: got v=%b ctrl=%0d tries=%0d control=%0d, want 0 1 2 1",
                     resp_valid, resp_ctrl, resp_tries, control);
        end
    endtask

    task automatic test_last();
        send(8'h27);
        n_cmp++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL search_flags: got busy=%b rdy=%b, want 1 0", busy, req_ready);
        end
        wait_resp();
    endtask

    task automatic test_unroutable();
        send(8'h4E);
        wait_resp();
        @(negedge clk);
        n_cmp++;
        if (control !== 5'd31) begin
            n_bad++;
            $display("FAIL unroutable_control: got %0d want 31", control);
        end
        send(8'h00);
        wait_resp();
        n_cmp++;
        if (control !== 5'd31) begin
            n_bad++;
            $display("FAIL duplicate_control: got %0d want 31", control);
        end
    endtask

    task automatic test_abort();
        send(8'h27);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        n_cmp++;
        if ({resp_valid, control, req_ready, busy} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_state: got v=%b control=%0d rdy=%b busy=%b, want 0 0 1 0",
                     resp_valid, control, req_ready, busy);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(8'hE4);
        wait_resp();
    endtask

    task automatic test_ignore();
        int unsigned a0;
        int k = 0;
        req_valid = 1'b1;
        req_dst   = 8'h27;
        a0 = cyc + 1;
        sb.push_back(predict(8'h27, a0));
        @(negedge clk);
        req_dst = 8'hE4;
        sb.push_back(predict(8'hE4, a0 + 33));
        do begin
            @(negedge clk);
            k++;
        end while (resp_valid !== 1'b1 && k < 40);
        n_cmp++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_ready: got v=%b rdy=%b, want 1 1", resp_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp();
    endtask

    task automatic test_back_to_back();
        int p[4];
        int j, t;
        logic [7:0] dst;
        for (int i = 0; i < 10; i++) begin
            p = '{0, 1, 2, 3};
            for (int s = 3; s > 0; s--) begin
                j = $urandom_range(s, 0);
                t = p[s]; p[s] = p[j]; p[j] = t;
            end
            dst = {2'(p[3]), 2'(p[2]), 2'(p[1]), 2'(p[0])};
            if (i % 3 == 2) dst = 8'($urandom);
            send(dst);
            wait_resp();
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_swap();
        test_last();
        test_unroutable();
        test_abort();
        test_ignore();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d pending responses, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crossbar_route_ctrl.md
CROSSBAR_ROUTE_CTRL -- requirements
Module: crossbar_route_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  route request present.
REQ-006 req_dst  input  8  destinations: [1:0]=in1, [3:2]=in2, [5:4]=in3, [7:6]=in4; 0..3 = out1..out4.
REQ-007 req_ready  output  1  high only in IDLE; request accepted on clk edge with req_valid&&req_ready.
REQ-008 resp_valid  output  1  one-cycle result pulse.
REQ-009 resp_ok  output  1  1 = route found; valid with resp_valid.
REQ-010 resp_ctrl  output  5  found configuration; valid with resp_valid&&resp_ok.
REQ-011 resp_tries  output  6  candidates examined (0..32); valid with resp_valid.
REQ-012 control  output  5  registered configuration driving the 4x4 crossbar control port.
REQ-013 busy  output  1  high in SEARCH.

Function
REQ-014 Crossbar model, one 2x2 switch per control bit; bit=0 straight (top->top), bit=1 crossed: S0(c0): in1,in2 -> a,b; S3(c3): in3,in4 -> y,w; S2(c2): b,y -> x,z; S1(c1): a,x -> out1,out2; S4(c4): z,w -> out3,out4.
REQ-015 States SHALL be IDLE and SEARCH; result reporting happens on the transition back to IDLE.
REQ-016 On accept, req_dst SHALL be latched; later req_dst changes have no effect on the request in progress.
REQ-017 If the latched req_dst is not a permutation (duplicate destination), the block SHALL stay in IDLE and pulse resp_valid=1, resp_ok=0, resp_tries=0 in the cycle after accept.
REQ-018 Otherwise the block SHALL enter SEARCH with candidate counter cand=0.
REQ-019 Each SEARCH cycle SHALL evaluate cand through the REQ-014 model and compare the result with the latched destinations.
REQ-020 On a match, the block SHALL go to IDLE and, in the next cycle, pulse resp_valid=1 and resp_ok=1, with resp_ctrl=cand and resp_tries=cand+1; control SHALL load cand on the same edge.
REQ-021 On no match with cand=31, the block SHALL go to IDLE and pulse resp_valid=1, resp_ok=0, resp_tries=32; control SHALL be unchanged.
REQ-022 On no match with cand<31, cand SHALL increment by one.
REQ-023 The lowest-numbered matching configuration SHALL always be reported; latency from accept edge to resp_valid = resp_tries cycles (1..32).
REQ-024 req_ready SHALL be high in the same cycle as resp_valid, allowing back-to-back requests.
REQ-025 req_valid SHALL be ignored while busy; no queuing.
REQ-026 control SHALL change only on a successful search or on reset.
REQ-027 resp_ctrl and resp_tries SHALL hold their last values between pulses.

Reset
REQ-028 rst SHALL force IDLE, cand=0, control=5'b00000, resp_valid=0, resp_ok=0, resp_ctrl=0, resp_tries=0, busy=0 and req_ready=1 from the next edge, including mid-SEARCH.
REQ-029 A search aborted by reset SHALL produce no resp_valid pulse.

Verification
REQ-030 Identity, req_dst=8'hE4 -> resp_valid 1 cycle after accept, ok=1, ctrl=5'b00000, tries=1.
REQ-031 Swap in1/in2, req_dst=8'hE1 -> ok=1, ctrl=5'b00001 (not 5'b00010), tries=2, control=5'b00001.
REQ-032 Last candidate, req_dst=8'h27 (in1->out4, in2->out2, in3->out3, in4->out1) -> ok=1, ctrl=5'b11111, tries=32, latency 32.
REQ-033 Unroutable, req_dst=8'h4E -> ok=0, tries=32, control holds previous value; duplicate req_dst=8'h00 -> ok=0, tries=0, 1 cycle after accept.
REQ-034 rst asserted at cand=10 of the 8'h27 search -> no resp_valid, control=0, req_ready=1 next cycle; a new 8'hE4 request completes normally.
REQ-035 req_valid held high during SEARCH with a different req_dst -> ignored; the next request is accepted in the resp_valid cycle.
